// File: rtl/clock_alarm.sv
// HH:MM:SS clock with settable alarm, blinking set fields and BCD digit outputs.
// Timekeeping is internal 24h BCD; the 12h view is derived only at the display.
module clock_alarm #(
  parameter int CLK_HZ      = 50000000,
  parameter int BLINK_HZ    = 3,
  parameter int INIT_HH     = 12,
  parameter int INIT_MM     = 0,
  parameter int INIT_SS     = 0,
  parameter bit INIT_IS_24H = 1'b0,
  parameter int INIT_AL_HH  = 7,
  parameter int INIT_AL_MM  = 0,
  parameter int ALARM_SECS  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] horas_decenas,
  output logic [3:0] horas_unidades,
  output logic [3:0] minutos_decenas,
  output logic [3:0] minutos_unidades,
  output logic [3:0] segundos_decenas,
  output logic [3:0] segundos_unidades,
  output logic       flag_pm,
  output logic       flag_24h,
  output logic [2:0] mode,
  output logic       alarm_on,
  output logic       alarm_ring
);

  localparam int PW   = $clog2(CLK_HZ);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [7:0] INIT_H  = {4'(INIT_HH / 10), 4'(INIT_HH % 10)};
  localparam logic [7:0] INIT_M  = {4'(INIT_MM / 10), 4'(INIT_MM % 10)};
  localparam logic [7:0] INIT_S  = {4'(INIT_SS / 10), 4'(INIT_SS % 10)};
  localparam logic [7:0] INIT_AH = {4'(INIT_AL_HH / 10), 4'(INIT_AL_HH % 10)};
  localparam logic [7:0] INIT_AM = {4'(INIT_AL_MM / 10), 4'(INIT_AL_MM % 10)};

  typedef enum logic [2:0] {
    M_NORMAL   = 3'd0,
    M_SET_MIN  = 3'd1,
    M_SET_HOUR = 3'd2,
    M_AL_MIN   = 3'd3,
    M_AL_HOUR  = 3'd4
  } mode_t;

  mode_t          state;
  logic [3:0]     sync1, sync2, sync_prev;
  logic [3:0]     press;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [BW-1:0]  bcnt;
  logic           blink;
  logic [7:0]     time_h, time_m, time_s;
  logic [7:0]     al_h, al_m;
  logic [7:0]     ring_cnt;
  logic [7:0]     nx_h, nx_m, nx_s;
  logic           carry_s, carry_m, ring_hit;
  logic           show_alarm;
  logic [7:0]     src_h, src_m, disp_h, disp_m, disp_s;

  // BCD increment with 59 -> 00 wrap, {tens, units}.
  function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)          r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // 00 shows as 12, 13..23 fold down by twelve.
  function automatic logic [7:0] to_12h(input logic [7:0] h);
    logic [4:0] bin, adj;
    logic [7:0] r;
    bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (bin == 5'd0)       adj = 5'd12;
    else if (bin > 5'd12)  adj = bin - 5'd12;
    else                   adj = bin;
    if (adj >= 5'd10) r = {4'd1, 4'(adj - 5'd10)};
    else              r = {4'd0, 4'(adj)};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 4'hF;
      sync2     <= 4'hF;
      sync_prev <= 4'hF;
    end else begin
      sync1     <= btn;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign press = sync_prev & ~sync2;
  assign tick  = (presc == PW'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      bcnt  <= '0;
      blink <= 1'b1;
    end else begin
      if (state == M_SET_MIN && press[2]) presc <= '0;
      else if (tick)                      presc <= '0;
      else                                presc <= presc + PW'(1);

      if (state == M_NORMAL) begin
        bcnt  <= '0;
        blink <= 1'b1;
      end else if (bcnt == BW'(HALF - 1)) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt  <= bcnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= M_NORMAL;
      flag_24h <= INIT_IS_24H;
    end else begin
      if (press[1]) begin
        case (state)
          M_NORMAL:   state <= M_SET_MIN;
          M_SET_MIN:  state <= M_SET_HOUR;
          M_SET_HOUR: state <= M_AL_MIN;
          M_AL_MIN:   state <= M_AL_HOUR;
          default:    state <= M_NORMAL;
        endcase
      end
      if (press[0]) flag_24h <= ~flag_24h;
    end
  end

  assign mode = state;

  always_comb begin
    carry_s  = (time_s == 8'h59);
    carry_m  = carry_s && (time_m == 8'h59);
    nx_s     = inc_bcd60(time_s);
    nx_m     = carry_s ? inc_bcd60(time_m) : time_m;
    nx_h     = carry_m ? inc_bcd24(time_h) : time_h;
    // The tick rolling seconds to 00 lands on the alarm minute.
    ring_hit = alarm_on && (state == M_NORMAL) && tick && carry_s &&
               (nx_h == al_h) && (nx_m == al_m);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_h <= INIT_H;
      time_m <= INIT_M;
      time_s <= INIT_S;
      al_h   <= INIT_AH;
      al_m   <= INIT_AM;
    end else begin
      case (state)
        M_NORMAL: if (tick) begin
          time_h <= nx_h;
          time_m <= nx_m;
          time_s <= nx_s;
        end
        M_SET_MIN: if (press[2]) begin
          time_m <= inc_bcd60(time_m);
          time_s <= 8'h00;
        end
        M_SET_HOUR: if (press[2]) time_h <= inc_bcd24(time_h);
        M_AL_MIN:   if (press[2]) al_m   <= inc_bcd60(al_m);
        M_AL_HOUR:  if (press[2]) al_h   <= inc_bcd24(al_h);
        default: ;
      endcase
    end
  end

  // A btn[3] press always silences; it only toggles arming when not ringing.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_on   <= 1'b0;
      alarm_ring <= 1'b0;
      ring_cnt   <= 8'd0;
    end else if (press[3]) begin
      alarm_ring <= 1'b0;
      if (!alarm_ring) alarm_on <= ~alarm_on;
    end else if (ring_hit) begin
      alarm_ring <= 1'b1;
      ring_cnt   <= 8'd0;
    end else if (alarm_ring && tick) begin
      if (ring_cnt == 8'(ALARM_SECS - 1)) alarm_ring <= 1'b0;
      else                                ring_cnt   <= ring_cnt + 8'd1;
    end
  end

  always_comb begin
    show_alarm = (state == M_AL_MIN) || (state == M_AL_HOUR);
    src_h      = show_alarm ? al_h : time_h;
    src_m      = show_alarm ? al_m : time_m;
    disp_h     = flag_24h ? src_h : to_12h(src_h);
    disp_m     = src_m;
    disp_s     = show_alarm ? 8'hFF : time_s;
    if (!blink && (state == M_SET_HOUR || state == M_AL_HOUR)) disp_h = 8'hFF;
    if (!blink && (state == M_SET_MIN  || state == M_AL_MIN))  disp_m = 8'hFF;
  end

  assign flag_pm           = (src_h >= 8'h12);
  assign horas_decenas     = disp_h[7:4];
  assign horas_unidades    = disp_h[3:0];
  assign minutos_decenas   = disp_m[7:4];
  assign minutos_unidades  = disp_m[3:0];
  assign segundos_decenas  = disp_s[7:4];
  assign segundos_unidades = disp_s[3:0];

endmodule

// File: tb/tb_clock_alarm.sv
// Bench for clock_alarm: reference model keeps time as seconds-of-day and the
// alarm as minutes-of-day; every output is compared on the falling edge.
module tb_clock_alarm;
  localparam int CLK    = 10;
  localparam int ALSECS = 3;
  localparam int HALF   = CLK / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'hF;
  logic [3:0] horas_decenas, horas_unidades, minutos_decenas, minutos_unidades;
  logic [3:0] segundos_decenas, segundos_unidades;
  logic       flag_pm, flag_24h, alarm_on, alarm_ring;
  logic [2:0] mode;

  int n_checks = 0;
  int n_errors = 0;

  clock_alarm #(
    .CLK_HZ(CLK), .BLINK_HZ(1), .INIT_HH(23), .INIT_MM(59), .INIT_SS(58),
    .INIT_IS_24H(1'b1), .INIT_AL_HH(7), .INIT_AL_MM(0), .ALARM_SECS(ALSECS)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn),
    .horas_decenas(horas_decenas), .horas_unidades(horas_unidades),
    .minutos_decenas(minutos_decenas), .minutos_unidades(minutos_unidades),
    .segundos_decenas(segundos_decenas), .segundos_unidades(segundos_unidades),
    .flag_pm(flag_pm), .flag_24h(flag_24h), .mode(mode),
    .alarm_on(alarm_on), .alarm_ring(alarm_ring)
  );

  // clock/reset
  always #5 clk = ~clk;

  int         m_tsec = 23 * 3600 + 59 * 60 + 58;
  int         m_almin = 7 * 60;
  int         m_mode = 0, m_presc = 0, m_n = 0, m_rcnt = 0;
  bit         m_fmt = 1'b1, m_alon = 1'b0, m_ring = 1'b0;
  logic [3:0] h1 = 4'hF, h2 = 4'hF, h3 = 4'hF;

  always @(posedge clk) begin : ref_model
    logic [3:0] p;
    bit tick, hit;
    int om;
    if (reset) begin
      m_tsec = 23 * 3600 + 59 * 60 + 58; m_almin = 7 * 60;
      m_mode = 0; m_presc = 0; m_n = 0; m_rcnt = 0;
      m_fmt = 1'b1; m_alon = 1'b0; m_ring = 1'b0;
      h1 = 4'hF; h2 = 4'hF; h3 = 4'hF;
    end else begin
      p    = h3 & ~h2;
      tick = (m_presc == CLK - 1);
      om   = m_mode;
      hit  = 1'b0;
      m_presc = (om == 1 && p[2]) ? 0 : (m_presc + 1) % CLK;
      m_n     = (om == 0) ? 0 : m_n + 1;
      if (p[1]) m_mode = (m_mode + 1) % 5;
      if (p[0]) m_fmt = !m_fmt;
      case (om)
        0: if (tick) begin
          m_tsec = (m_tsec + 1) % 86400;
          hit = m_alon && (m_tsec % 60 == 0) && (m_tsec / 60 == m_almin);
        end
        1: if (p[2]) m_tsec = (m_tsec / 3600) * 3600 + (((m_tsec / 60) % 60 + 1) % 60) * 60;
        2: if (p[2]) m_tsec = ((m_tsec / 3600 + 1) % 24) * 3600 + m_tsec % 3600;
        3: if (p[2]) m_almin = (m_almin / 60) * 60 + (m_almin % 60 + 1) % 60;
        4: if (p[2]) m_almin = ((m_almin / 60 + 1) % 24) * 60 + m_almin % 60;
        default: ;
      endcase
      if (p[3]) begin
        if (!m_ring) m_alon = !m_alon;
        m_ring = 1'b0;
      end else if (hit) begin
        m_ring = 1'b1; m_rcnt = 0;
      end else if (m_ring && tick) begin
        m_rcnt++;
        if (m_rcnt == ALSECS) m_ring = 1'b0;
      end
      h3 = h2; h2 = h1; h1 = btn;
    end
  end

  task automatic chk(input string tag, input integer got, input integer exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_model();
    int sh, sm, dh, ht, hu, mt, mu, st, su;
    bit vis;
    if (m_mode >= 3) begin sh = m_almin / 60; sm = m_almin % 60; end
    else begin sh = m_tsec / 3600; sm = (m_tsec / 60) % 60; end
    dh  = m_fmt ? sh : (sh == 0 ? 12 : (sh > 12 ? sh - 12 : sh));
    vis = ((m_n / HALF) % 2) == 0;
    ht = dh / 10; hu = dh % 10; mt = sm / 10; mu = sm % 10;
    st = (m_tsec % 60) / 10; su = m_tsec % 10;
    if (!vis && (m_mode == 2 || m_mode == 4)) begin ht = 15; hu = 15; end
    if (!vis && (m_mode == 1 || m_mode == 3)) begin mt = 15; mu = 15; end
    if (m_mode >= 3) begin st = 15; su = 15; end
    chk("m_hd", horas_decenas, ht);      chk("m_hu", horas_unidades, hu);
    chk("m_md", minutos_decenas, mt);    chk("m_mu", minutos_unidades, mu);
    chk("m_sd", segundos_decenas, st);   chk("m_su", segundos_unidades, su);
    chk("m_pm", flag_pm, sh >= 12);      chk("m_24h", flag_24h, m_fmt);
    chk("m_mode", mode, m_mode);         chk("m_alon", alarm_on, m_alon);
    chk("m_ring", alarm_ring, m_ring);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_model();
    end
  endtask

  task automatic press(input int i);
    btn[i] = 1'b0; cyc(2);
    btn[i] = 1'b1; cyc(2);
  endtask

  task automatic press_n(input int i, input int n);
    repeat (n) press(i);
  endtask

  task automatic chk_digits(input string tag, input int ht, input int hu, input int mt,
                            input int mu, input int st, input int su);
    chk({tag, "_hd"}, horas_decenas, ht);    chk({tag, "_hu"}, horas_unidades, hu);
    chk({tag, "_md"}, minutos_decenas, mt);  chk({tag, "_mu"}, minutos_unidades, mu);
    chk({tag, "_sd"}, segundos_decenas, st); chk({tag, "_su"}, segundos_unidades, su);
  endtask

  task automatic wait_ring(input string tag);
    int k = 0;
    while (alarm_ring !== 1'b1 && k < 1000) begin cyc(1); k++; end
    chk(tag, alarm_ring, 1);
  endtask

  initial begin
    int cnt;
    logic [3:0] b;
    repeat (2) @(negedge clk);
    check_model();
    chk_digits("rst", 2, 3, 5, 9, 5, 8);
    chk("rst_mode", mode, 0); chk("rst_24h", flag_24h, 1);
    chk("rst_alon", alarm_on, 0); chk("rst_ring", alarm_ring, 0);
    reset = 1'b0;
    cyc(20);
    chk_digits("rollover", 0, 0, 0, 0, 0, 0);
    chk("rollover_pm", flag_pm, 0);

    // randomized button activity with an occasional reset pulse
    repeat (200) begin
      b = 4'hF;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 4) == 0) b[i] = 1'b0;
      btn = b;
      reset = ($urandom_range(0, 59) == 0);
      cyc($urandom_range(1, 6));
      reset = 1'b0;
    end
    btn = 4'hF;
    cyc(4);

    reset = 1'b1; cyc(1); reset = 1'b0;
    press(1);
    chk("setmin_mode", mode, 1);
    press_n(2, 31);
    press(1); press(2);
    chk("set_0030_md", minutos_decenas, 3); chk("set_0030_mu", minutos_unidades, 0);
    chk("set_0030_sd", segundos_decenas, 0); chk("set_0030_su", segundos_unidades, 0);
    press(0);
    press_n(1, 3);
    chk("h12_hd", horas_decenas, 1); chk("h12_hu", horas_unidades, 2);
    chk("h12_md", minutos_decenas, 3); chk("h12_mu", minutos_unidades, 0);
    chk("h12_pm", flag_pm, 0); chk("h12_24h", flag_24h, 0);

    press(1); press_n(2, 35); press(1); press_n(2, 13); press_n(1, 3);
    chk("h13_hd", horas_decenas, 0); chk("h13_hu", horas_unidades, 1);
    chk("h13_md", minutos_decenas, 0); chk("h13_mu", minutos_unidades, 5);
    chk("h13_pm", flag_pm, 1);
    press(0);
    chk("h24_hd", horas_decenas, 1); chk("h24_hu", horas_unidades, 3);
    chk("h24_flag", flag_24h, 1);

    press(1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (minutos_decenas == 4'hF) cnt++;
    end
    chk("blink_half", cnt, 5);
    press_n(2, 3);
    chk("setmin_hd", horas_decenas, 1); chk("setmin_hu", horas_unidades, 3);
    chk("setmin_sd", segundos_decenas, 0); chk("setmin_su", segundos_unidades, 0);

    press_n(2, 52); press(1); press_n(2, 18); press(1); press(2);
    chk("alview_hd", horas_decenas, 0); chk("alview_hu", horas_unidades, 7);
    chk("alview_sd", segundos_decenas, 15); chk("alview_su", segundos_unidades, 15);
    press_n(1, 2);
    press(3);
    chk("arm", alarm_on, 1);
    wait_ring("ring1_start");
    chk_digits("ring1", 0, 7, 0, 1, 0, 0);
    chk("ring1_on", alarm_on, 1);
    cyc(25);
    chk("ring1_mid", alarm_ring, 1);
    cyc(10);
    chk("ring1_timeout", alarm_ring, 0);

    press(1); press_n(2, 59); press_n(1, 4);
    wait_ring("ring2_start");
    press(3);
    chk("ack_ring", alarm_ring, 0); chk("ack_on", alarm_on, 1);
    press(3);
    chk("disarm", alarm_on, 0);

    press(3);
    press(1); press_n(2, 59); press_n(1, 4);
    wait_ring("ring3_start");
    press_n(1, 4);
    chk("ring3_mode", mode, 4); chk("ring3_ring", alarm_ring, 1);
    reset = 1'b1; cyc(1);
    chk("rst2_mode", mode, 0); chk("rst2_ring", alarm_ring, 0);
    chk("rst2_on", alarm_on, 0);
    chk_digits("rst2", 2, 3, 5, 9, 5, 8);
    reset = 1'b0;
    press_n(1, 3);
    chk("rst2_al_hd", horas_decenas, 0); chk("rst2_al_hu", horas_unidades, 7);
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
